// File: rtl/rf_write_arbiter_pkg.sv
// rtl/rf_write_arbiter_pkg.sv - shared register-file widths, writeback source ids, pointer helper
package rf_write_arbiter_pkg;
  localparam int RF_AW   = 4;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 16;
  localparam int SRC_W   = 3;

  localparam int WB_SRC_ALU   = 0;
  localparam int WB_SRC_LOAD  = 1;
  localparam int WB_SRC_LINK  = 2;
  localparam int WB_SRC_DEBUG = 3;

  // Round-robin successor of a granted index, wrapping at nreq-1.
  function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] idx, input int nreq);
    if (int'(idx) >= nreq - 1) return '0;
    return idx + SRC_W'(1);
  endfunction
endpackage

// File: rtl/rf_write_arbiter_rr_pick.sv
// rtl/rf_write_arbiter_rr_pick.sv - combinational round-robin pick: first valid at or after ptr
module rr_pick
  import rf_write_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [SRC_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [SRC_W-1:0] idx
);
  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = SRC_W'(j);
      end
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter sharing the RF write port among writeback sources
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = RF_AW,
  parameter int DW       = RF_DW,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  input  logic             stall,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  output logic [SRC_W-1:0] wr_src
);
  logic [SRC_W-1:0] ptr;
  logic [NREQ-1:0]  grant;
  logic [SRC_W-1:0] idx;
  logic             xfer;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (idx)
  );

  // Stall and reset both block the grant so nothing is acked that won't be written.
  assign req_ready = (rst || stall) ? '0 : grant;
  assign xfer      = |req_ready;
  assign sel_addr  = req_addr[int'(idx)*AW +: AW];
  assign sel_data  = req_data[int'(idx)*DW +: DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_src  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (xfer) begin
        // R0 writes are acked and consume a turn but never reach the register file.
        wr_en   <= !((ZERO_REG != 0) && (sel_addr == '0));
        wr_addr <= sel_addr;
        wr_data <= sel_data;
        wr_src  <= idx;
        ptr     <= rr_next(idx, NREQ);
      end
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [15:0]  req_addr;
  logic [127:0] req_data;
  logic         stall;

  logic [3:0]   req_ready, req_ready_nz;
  logic         wr_en, wr_en_nz;
  logic [3:0]   wr_addr, wr_addr_nz;
  logic [31:0]  wr_data, wr_data_nz;
  logic [2:0]   wr_src, wr_src_nz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.NREQ(4), .AW(4), .DW(32), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_src(wr_src)
  );

  rf_write_arbiter #(.NREQ(4), .AW(4), .DW(32), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready_nz), .stall(stall), .wr_en(wr_en_nz), .wr_addr(wr_addr_nz),
    .wr_data(wr_data_nz), .wr_src(wr_src_nz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [31:0] d);
    req_addr[i*4 +: 4]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; req_valid = 4'b1111;
    req_addr = '0; req_data = '0;
    for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 32'h1000_0000 + i);

    // Reset held two cycles with every requester valid
    for (int c = 0; c < 2; c++) begin
      step();
      settle();
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_wr_en", 32'(wr_en), 32'h0);
      check("rst_wr_addr", 32'(wr_addr), 32'h0);
    end
    check("rst_wr_data", wr_data, 32'h0);
    check("rst_wr_src", 32'(wr_src), 32'h0);
    req_valid = 4'b0000;
    rst = 1'b0;

    // Single request from requester 2
    step();
    set_req(2, 4'd5, 32'hDEADBEEF);
    req_valid = 4'b0100;
    settle();
    check("single_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0000;
    check("single_wr_en", 32'(wr_en), 32'h1);
    check("single_wr_addr", 32'(wr_addr), 32'h5);
    check("single_wr_data", wr_data, 32'hDEADBEEF);
    check("single_wr_src", 32'(wr_src), 32'h2);

    // Short reset to bring the pointer back to 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(2, 4'd3, 32'h1000_0002);

    // All four valid for 8 cycles: strict rotation 0,1,2,3,...
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      settle();
      check($sformatf("rot_ready_%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      step();
      check($sformatf("rot_wr_en_%0d", c), 32'(wr_en), 32'h1);
      check($sformatf("rot_wr_src_%0d", c), 32'(wr_src), 32'(c % 4));
      check($sformatf("rot_wr_addr_%0d", c), 32'(wr_addr), 32'((c % 4) + 1));
    end
    req_valid = 4'b0000;
    step();
    check("idle_wr_en", 32'(wr_en), 32'h0);
    check("idle_hold_addr", 32'(wr_addr), 32'h4);
    check("idle_hold_src", 32'(wr_src), 32'h3);

    // Stall three cycles, then grants resume at 0 then 1
    req_valid = 4'b0011;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("stall_ready_%0d", c), 32'(req_ready), 32'h0);
      step();
      check($sformatf("stall_wr_en_%0d", c), 32'(wr_en), 32'h0);
    end
    stall = 1'b0;
    settle();
    check("unstall_ready0", 32'(req_ready), 32'h1);
    step();
    check("unstall_src0", 32'(wr_src), 32'h0);
    check("unstall_en0", 32'(wr_en), 32'h1);
    settle();
    check("unstall_ready1", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0000;
    check("unstall_src1", 32'(wr_src), 32'h1);

    // Zero-register write from requester 1 (pointer is 2 here)
    set_req(1, 4'd0, 32'h7);
    req_valid = 4'b0010;
    settle();
    check("zero_ready", 32'(req_ready), 32'h2);
    check("zero_ready_nz", 32'(req_ready_nz), 32'h2);
    step();
    req_valid = 4'b1111;
    set_req(1, 4'd2, 32'h1000_0001);
    check("zero_wr_en", 32'(wr_en), 32'h0);
    check("zero_nz_wr_en", 32'(wr_en_nz), 32'h1);
    check("zero_nz_wr_addr", 32'(wr_addr_nz), 32'h0);
    check("zero_nz_wr_data", wr_data_nz, 32'h7);
    settle();
    check("zero_ptr_next", 32'(req_ready), 32'h4);
    step();
    check("zero_after_src", 32'(wr_src), 32'h2);

    // Reset mid-stream with pointer at 3
    settle();
    check("mid_ready_pre", 32'(req_ready), 32'h8);
    rst = 1'b1;
    settle();
    check("mid_ready_rst", 32'(req_ready), 32'h0);
    step();
    check("mid_wr_en", 32'(wr_en), 32'h0);
    rst = 1'b0;
    req_valid = 4'b0110;
    settle();
    check("mid_first_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0000;
    check("mid_first_src", 32'(wr_src), 32'h1);
    check("mid_first_en", 32'(wr_en), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
